result_collect_fifo: RTL

- Downstream stage of the registered adder (start/a/b -> y/valid).
- Captures every one-cycle `valid`/`y` result pulse into a small FIFO.
- Presents stored results to a consumer over a ready/valid handshake.
- Flags and counts results that are dropped when the buffer is full.

---
 rtl/result_collect_fifo.sv | 137 +++++++++++++
 1 files changed

// File: rtl/result_collect_fifo.sv
// Result collection FIFO behind the registered adder: captures every valid/y pulse,
// serves it over ready/valid, and counts results dropped while full.
module result_collect_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          overflow,
  output logic [7:0]    drop_cnt,
  input  logic          clr_ovf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  logic          push_s, pop_s, drop_s;

  // Next-state logic: handshakes, pointers, occupancy, registered head and drop tracking.
  always_comb begin
    pop_s  = out_valid_q && out_ready;
    push_s = in_valid && ((count_q != DEPTH_C) || pop_s);
    drop_s = in_valid && !push_s;

    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push_s) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    full_d      = (count_d == DEPTH_C);
    empty_d     = (count_d == {CW{1'b0}});
    out_valid_d = !empty_d;

    // The new head may be the entry being written this very edge (empty, or one left and popped).
    if (empty_d) begin
      out_data_d = {W{1'b0}};
    end else if (push_s && (wr_ptr_q == rd_ptr_d)) begin
      out_data_d = in_data;
    end else begin
      out_data_d = mem_q[rd_ptr_d];
    end

    if (drop_s) begin
      overflow_d = 1'b1;
      if (clr_ovf) begin
        drop_cnt_d = 8'd1;
      end else if (drop_cnt_q == 8'd255) begin
        drop_cnt_d = 8'd255;
      end else begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
      drop_cnt_d = 8'd0;
    end else begin
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
    end
  end

  // State registers; reset discards all stored entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {W{1'b0}};
      end
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      count_q     <= {CW{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {W{1'b0}};
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= 8'd0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign count     = count_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

endmodule
